// File: rtl/jump_ctrl_if.sv
// Bundle of the fetch, retire, trap and redirect signals of jump_ctrl.
// The slave modport belongs to jump_ctrl; the master modport drives it.
interface jump_ctrl_if #(
  parameter int ADDR_W = 32
);
  // Fetch side: one entry per issued fetch
  logic              fetch_valid_i;
  logic [ADDR_W-1:0] fetch_addr_i;
  logic              predict_to_jump_i;
  logic [ADDR_W-1:0] predict_next_i;
  // Execute side: one retiring instruction per cycle
  logic              ex_valid_i;
  logic              ex_is_branch_i;
  logic              ex_is_jump_i;
  logic              ex_taken_i;
  logic [ADDR_W-1:0] ex_target_i;
  // Traps
  logic              int_req_i;
  logic [ADDR_W-1:0] int_addr_i;
  logic              exc_req_i;
  logic [ADDR_W-1:0] exc_addr_i;
  // Redirect results and status
  logic [2:0]        jump_cause_o;
  logic [ADDR_W-1:0] jump_from_addr_o;
  logic [ADDR_W-1:0] jump_to_addr_o;
  logic              flush_o;
  logic              hold_req_o;
  logic [15:0]       mispredict_cnt_o;
  logic              err_o;

  modport slave (
    input  fetch_valid_i, fetch_addr_i, predict_to_jump_i, predict_next_i,
    input  ex_valid_i, ex_is_branch_i, ex_is_jump_i, ex_taken_i, ex_target_i,
    input  int_req_i, int_addr_i, exc_req_i, exc_addr_i,
    output jump_cause_o, jump_from_addr_o, jump_to_addr_o, flush_o,
    output hold_req_o, mispredict_cnt_o, err_o
  );

  modport master (
    output fetch_valid_i, fetch_addr_i, predict_to_jump_i, predict_next_i,
    output ex_valid_i, ex_is_branch_i, ex_is_jump_i, ex_taken_i, ex_target_i,
    output int_req_i, int_addr_i, exc_req_i, exc_addr_i,
    input  jump_cause_o, jump_from_addr_o, jump_to_addr_o, flush_o,
    input  hold_req_o, mispredict_cnt_o, err_o
  );
endinterface

// File: rtl/jump_ctrl.sv
// Jump controller: tracks fetch-time predictions in a small FIFO, compares
// them with what EX actually retires, and issues one-cycle redirects for
// mispredictions, interrupts and exceptions, followed by a drain window.
module jump_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int DEPTH        = 4,
  parameter int DRAIN_CYCLES = 2
) (
  input logic         clk,
  input logic         rst_n,
  jump_ctrl_if.slave  bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int DCNT_W = $clog2(DRAIN_CYCLES) + 1;

  localparam logic [2:0] C_NONE   = 3'b000;
  localparam logic [2:0] C_PNY    = 3'b001;
  localparam logic [2:0] C_PYN    = 3'b010;
  localparam logic [2:0] C_NOCOND = 3'b011;
  localparam logic [2:0] C_INT    = 3'b100;
  localparam logic [2:0] C_EXC    = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_REDIRECT, S_DRAIN} state_t;

  state_t              r_state;
  logic [DCNT_W-1:0]   r_drain_cnt;
  logic [2:0]          r_cause;
  logic [ADDR_W-1:0]   r_from;
  logic [ADDR_W-1:0]   r_to;
  logic                r_flush;
  logic [15:0]         r_mis_cnt;
  logic                r_err;

  logic [ADDR_W-1:0]   r_fifo_addr [DEPTH];
  logic                r_fifo_pj   [DEPTH];
  logic [ADDR_W-1:0]   r_fifo_next [DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_ex_idle;
  logic                w_pop;
  logic [ADDR_W-1:0]   w_head_addr;
  logic                w_head_pj;
  logic [ADDR_W-1:0]   w_head_next;
  logic                w_taken_flow;
  logic [ADDR_W-1:0]   w_actual_next;
  logic [2:0]          w_cause;
  logic [ADDR_W-1:0]   w_to;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_push    = bus.fetch_valid_i && !w_full && (r_state != S_REDIRECT);
  // Retires are only counted in IDLE; in REDIRECT/DRAIN they belong to the
  // squashed stream.
  assign w_ex_idle = bus.ex_valid_i && (r_state == S_IDLE);
  assign w_pop     = w_ex_idle && !w_empty;

  // An empty FIFO reads as all-zero so trap redirects report from=0
  assign w_head_addr = w_empty ? '0 : r_fifo_addr[r_rd_ptr];
  assign w_head_pj   = w_empty ? 1'b0 : r_fifo_pj[r_rd_ptr];
  assign w_head_next = w_empty ? '0 : r_fifo_next[r_rd_ptr];

  assign w_taken_flow  = bus.ex_is_jump_i || (bus.ex_is_branch_i && bus.ex_taken_i);
  assign w_actual_next = w_taken_flow ? bus.ex_target_i : (w_head_addr + ADDR_W'(4));

  assign bus.hold_req_o = w_full ||
                          ((r_count == CNT_W'(DEPTH - 1)) && w_push && !w_pop);

  // Redirect cause selection, highest priority first
  always_comb begin
    w_cause = C_NONE;
    w_to    = '0;
    if (bus.exc_req_i) begin
      w_cause = C_EXC;
      w_to    = bus.exc_addr_i;
    end else if (bus.int_req_i) begin
      w_cause = C_INT;
      w_to    = bus.int_addr_i;
    end else if (w_pop) begin
      if (bus.ex_is_branch_i && !w_head_pj && bus.ex_taken_i) begin
        w_cause = C_PNY;
        w_to    = w_actual_next;
      end else if (bus.ex_is_branch_i && w_head_pj && !bus.ex_taken_i) begin
        w_cause = C_PYN;
        w_to    = w_actual_next;
      end else if (w_taken_flow && (w_actual_next != w_head_next)) begin
        w_cause = C_NOCOND;
        w_to    = w_actual_next;
      end
    end
  end

  // Prediction storage; contents need no reset since count gates validity
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= bus.fetch_addr_i;
      r_fifo_pj[r_wr_ptr]   <= bus.predict_to_jump_i;
      r_fifo_next[r_wr_ptr] <= bus.predict_next_i;
    end
  end

  // FIFO pointers and occupancy; a REDIRECT cycle empties the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (r_state == S_REDIRECT) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Redirect FSM with registered one-cycle outputs, counters and error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_drain_cnt <= '0;
      r_cause     <= C_NONE;
      r_from      <= '0;
      r_to        <= '0;
      r_flush     <= 1'b0;
      r_mis_cnt   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_cause <= C_NONE;
      r_from  <= '0;
      r_to    <= '0;
      r_flush <= 1'b0;
      if (w_ex_idle && w_empty) r_err <= 1'b1;
      if (w_cause != C_NONE) begin
        r_state <= S_REDIRECT;
        r_cause <= w_cause;
        r_from  <= w_head_addr;
        r_to    <= w_to;
        r_flush <= 1'b1;
        if (((w_cause == C_PNY) || (w_cause == C_PYN)) && (r_mis_cnt != 16'hFFFF))
          r_mis_cnt <= r_mis_cnt + 16'd1;
      end else begin
        case (r_state)
          S_REDIRECT: begin
            r_state     <= S_DRAIN;
            r_drain_cnt <= DCNT_W'(DRAIN_CYCLES - 1);
          end
          S_DRAIN: begin
            if (r_drain_cnt == '0) r_state <= S_IDLE;
            else                   r_drain_cnt <= r_drain_cnt - 1'b1;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.jump_cause_o     = r_cause;
  assign bus.jump_from_addr_o = r_from;
  assign bus.jump_to_addr_o   = r_to;
  assign bus.flush_o          = r_flush;
  assign bus.mispredict_cnt_o = r_mis_cnt;
  assign bus.err_o            = r_err;
endmodule
